// File: rtl/bus_move_sequencer.sv
// Bus initiator moving register->register or immediate->register over the shared register bus; SEQ_READBACK_EN adds a verify read of dst.
// Latency from accept: reg move done in cycle 4 (6 with readback), immediate in 2 (4), out-of-range in 1.
// Backpressure: req_ready only in IDLE outside reset; requests presented while busy are not queued.
module bus_move_sequencer #(
    parameter  int WORD_SIZE = 8,
    parameter  int NUM_REGS  = 4,
    localparam int SEL_W     = $clog2(NUM_REGS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [SEL_W-1:0]              req_src,
    input  logic [SEL_W-1:0]              req_dst,
    input  logic                          req_imm_en,
    input  logic [WORD_SIZE-1:0]          req_imm,
    output logic [NUM_REGS-1:0]           reg_enable,
    output logic                          reg_read,
    output logic                          reg_write,
    input  logic [NUM_REGS*WORD_SIZE-1:0] reg_out,
    output logic [WORD_SIZE-1:0]          bus_value,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ   = 3'd1;
    localparam logic [2:0] ST_LATCH  = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_FAIL   = 3'd5;
`ifdef SEQ_READBACK_EN
    localparam logic [2:0] ST_VREAD  = 3'd6;
    localparam logic [2:0] ST_VCHECK = 3'd7;
`endif

    // One extra bit so the range check is meaningful for non-power-of-2 banks.
    localparam logic [SEL_W:0] NUM_REGS_W = (SEL_W+1)'(NUM_REGS);

    logic [2:0]           state_q, state_d;
    logic [SEL_W-1:0]     src_q, src_d;
    logic [SEL_W-1:0]     dst_q, dst_d;
    logic [WORD_SIZE-1:0] bus_q, bus_d;
    logic                 accept;
    logic                 src_bad;
    logic                 dst_bad;
    logic [WORD_SIZE-1:0] src_word;
`ifdef SEQ_READBACK_EN
    logic                 err_q, err_d;
    logic [WORD_SIZE-1:0] dst_word;
`endif

    function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            oh[i] = (idx == SEL_W'(i));
        end
        return oh;
    endfunction

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign src_bad   = !req_imm_en && ({1'b0, req_src} >= NUM_REGS_W);
    assign dst_bad   = {1'b0, req_dst} >= NUM_REGS_W;

    always_comb begin
        src_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (src_q == SEL_W'(i)) begin
                src_word = reg_out[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

`ifdef SEQ_READBACK_EN
    always_comb begin
        dst_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dst_q == SEL_W'(i)) begin
                dst_word = reg_out[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        bus_d   = bus_q;
`ifdef SEQ_READBACK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    src_d = req_src;
                    dst_d = req_dst;
`ifdef SEQ_READBACK_EN
                    err_d = 1'b0;
`endif
                    if (src_bad || dst_bad) begin
                        state_d = ST_FAIL;
                    end else if (req_imm_en) begin
                        bus_d   = req_imm;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ:  state_d = ST_LATCH;
            ST_LATCH: begin
                // Source register presented its data on the READ closing edge.
                bus_d   = src_word;
                state_d = ST_WRITE;
            end
`ifdef SEQ_READBACK_EN
            ST_WRITE:  state_d = ST_VREAD;
            ST_VREAD:  state_d = ST_VCHECK;
            ST_VCHECK: begin
                err_d   = (dst_word != bus_q);
                state_d = ST_DONE;
            end
`else
            ST_WRITE:  state_d = ST_DONE;
`endif
            ST_DONE:  state_d = ST_IDLE;
            ST_FAIL:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Moore decode: strobes depend only on registered state, so reset drops them at once.
    always_comb begin
        reg_enable = '0;
        reg_read   = 1'b0;
        reg_write  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state_q)
            ST_READ: begin
                reg_enable = onehot(src_q);
                reg_read   = 1'b1;
            end
            ST_WRITE: begin
                reg_enable = onehot(dst_q);
                reg_write  = 1'b1;
            end
`ifdef SEQ_READBACK_EN
            ST_VREAD: begin
                reg_enable = onehot(dst_q);
                reg_read   = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
`else
            ST_DONE: done = 1'b1;
`endif
            ST_FAIL: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus_value = bus_q;
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            bus_q   <= '0;
`ifdef SEQ_READBACK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            bus_q   <= bus_d;
`ifdef SEQ_READBACK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: doc/bus_move_sequencer.md
Name: bus_move_sequencer

Overview:
- Bus initiator for the bank of per-register bus slaves (enable/read/write/reset slave interface, registered read data).
- Accepts one move request per handshake: register-to-register, or immediate-to-register.
- Sequences enable/read/write strobes so data crosses the shared bus correctly, then signals completion.
- Sits between the control unit and the register bank; it is the only driver of the register strobes and the bus value.

Parameters:
- WORD_SIZE, 8, data width of the bus and of each register.
- NUM_REGS, 4, number of attached registers (2..16).
- SEL_W, $clog2(NUM_REGS), select width. Derived; never overridden.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request this cycle.
- req_src  in  SEL_W  source register index (ignored when req_imm_en=1).
- req_dst  in  SEL_W  destination register index.
- req_imm_en  in  1  1 = write req_imm instead of reading a source register.
- req_imm  in  WORD_SIZE  immediate value.
- reg_enable  out  NUM_REGS  one-hot enable, bit i drives register i.
- reg_read  out  1  shared read strobe.
- reg_write  out  1  shared write strobe.
- reg_out  in  NUM_REGS*WORD_SIZE  flattened register outputs; register i at [i*WORD_SIZE +: WORD_SIZE].
- bus_value  out  WORD_SIZE  value driven to all register inputs.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualified by done; 1 = request failed.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE.
  - reg_enable=0, reg_read=0, reg_write=0.
  - bus_value=0 (internal latch bus_q cleared), done=0, err=0, busy=0.
  - req_ready=0 while reset is high.
- Outputs are Moore, decoded from registered state and bus_q only. There is no combinational path from req_* to any output except req_ready.
- req_ready = (state==IDLE) && !reset. A request is accepted on a rising edge where req_valid && req_ready. req_* inputs are sampled only at acceptance.
- States and transitions:
  - IDLE: on accept, capture src/dst/imm.
    - Either index out of range (>= NUM_REGS; only possible when NUM_REGS is not a power of 2) -> FAIL.
    - Otherwise, imm_en=1 -> bus_q<=req_imm, go to WRITE.
    - Otherwise -> READ.
  - READ (1 cycle): reg_enable=onehot(src), reg_read=1. The source register loads its output on this cycle's closing edge -> LATCH.
  - LATCH (1 cycle): all strobes 0. At the edge, bus_q<=reg_out[src] -> WRITE.
  - WRITE (1 cycle): reg_enable=onehot(dst), reg_write=1, reg_read=0, bus_value=bus_q -> DONE. With SEQ_READBACK_EN, go to VREAD instead.
  - DONE (1 cycle): done=1, err=0 -> IDLE.
  - FAIL (1 cycle): done=1, err=1, no strobes issued -> IDLE.
- reg_read and reg_write are never high in the same cycle. At most one reg_enable bit is high.
- bus_value always shows bus_q, which holds the last moved value until the next move or reset.
- Latency from the accept edge:
  - Register move: WRITE is the 3rd cycle, done in the 4th, req_ready high again in the 5th.
  - Immediate: WRITE is the 1st cycle, done in the 2nd.
  - Out-of-range: done+err in the 1st cycle.
- src==dst is legal: read then write back the same value.
- req_valid while busy is ignored and not queued. The requester must hold it until acceptance.
- Reset mid-operation: strobes drop asynchronously, so no write is committed if reset hits during WRITE. No done pulse is produced for the aborted request.

Optional Feature:
- Macro: SEQ_READBACK_EN.
- Defined:
  - After WRITE the sequencer runs VREAD (enable[dst], read=1), then VCHECK, which compares reg_out[dst] against bus_q at its edge, then DONE.
  - err=1 with done on mismatch.
  - Register-move done moves to the 6th cycle; immediate done moves to the 4th.
- Undefined: VREAD and VCHECK do not exist; err is set only by out-of-range requests.

Test Plan:
1. Reset: assert reset for 3 cycles mid-idle -> all outputs 0 and req_ready=0 during reset; req_ready=1 on the first cycle after release.
2. Immediate: imm_en=1, imm=0xA5, dst=1 -> reg_enable=0010 and reg_write=1 in cycle 1; r1=0xA5; done=1, err=0 in cycle 2.
3. Move: with r1=0xA5, src=1, dst=2 -> strobes read(enable=0010), idle, write(enable=0100, bus_value=0xA5); r2=0xA5; done in cycle 4; req_valid held during busy is accepted only in cycle 5.
4. Range: NUM_REGS=3, dst=3 -> no strobes; done=1, err=1 in cycle 1; registers unchanged.
5. Abort: assert reset during WRITE of immediate 0x3C to r3 -> reg_write falls before the edge; r3 keeps its old value; no done pulse; next request completes normally.
6. SEQ_READBACK_EN: dst register model forced to ignore writes, move 0x5A -> done=1, err=1 in cycle 6. With a healthy model -> err=0.
